// File: rtl/pipe_pkg.sv
// pipe_pkg: shared control-bit layout and per-stage widths for pipeline stage registers.
package pipe_pkg;
  localparam int CTRL_WB_EN   = 0;
  localparam int CTRL_MEM_R   = 1;
  localparam int CTRL_MEM_W   = 2;
  localparam int CTRL_S       = 3;
  localparam int CTRL_BR      = 4;
  localparam int CTRL_EXE_LSB = 5;
  localparam int CTRL_EXE_W   = 3;
  localparam int PIPE_CTRL_W    = 8;
  localparam int IF_ID_DATA_W   = 64;
  localparam int ID_EXE_DATA_W  = 128;
  localparam int EXE_MEM_DATA_W = 96;
  localparam int MEM_WB_DATA_W  = 72;
  localparam int PIPE_CNT_W     = 16;
endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one valid+ctrl+data entry; flush beats load beats clear.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = PIPE_CTRL_W,
  parameter int DATA_W     = ID_EXE_DATA_W,
  parameter bit CLEAR_DATA = 1'b1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              flush,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLEAR_DATA) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready stage register with flush and saturating stall/flush counters.
// Define PIPE_STAGE_SKID_BUFFER_EN for a 2-deep buffer with a registered in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W              = PIPE_CTRL_W,
  parameter int DATA_W              = ID_EXE_DATA_W,
  parameter int CNT_W               = PIPE_CNT_W,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic              stall, emit, accept, main_load;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;
  assign stall  = out_valid & ~out_ready;
  assign emit   = out_valid & out_ready;
  assign accept = in_valid & in_ready;
`ifdef PIPE_STAGE_SKID_BUFFER_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  // skid_valid is only set while the main slot is stalled, so it refills main on emit
  assign in_ready    = flush | ~skid_valid;
  assign main_load   = (emit & skid_valid) | (accept & ~stall);
  assign main_ctrl_d = skid_valid ? skid_ctrl : in_ctrl;
  assign main_data_d = skid_valid ? skid_data : in_data;
  pipe_skid_slot #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA_ON_FLUSH)
  ) u_skid (
    .clk(clk), .rst(rst), .load(accept & stall), .clear(emit), .flush(flush),
    .d_ctrl(in_ctrl), .d_data(in_data),
    .valid(skid_valid), .ctrl(skid_ctrl), .data(skid_data)
  );
`else
  assign in_ready    = flush | ~out_valid | out_ready;
  assign main_load   = accept;
  assign main_ctrl_d = in_ctrl;
  assign main_data_d = in_data;
`endif
  pipe_skid_slot #(
    .CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLEAR_DATA(CLEAR_DATA_ON_FLUSH)
  ) u_main (
    .clk(clk), .rst(rst), .load(main_load), .clear(emit), .flush(flush),
    .d_ctrl(main_ctrl_d), .d_data(main_data_d),
    .valid(out_valid), .ctrl(out_ctrl), .data(out_data)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush && out_valid && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
endmodule
